// File: rtl/rv32_dmem_responder.sv
// Data-memory bus responder for the RV32 core: byte-enabled local RAM plus a
// 16-byte timer register window, with a wait-state FSM stretching reads.
module rv32_dmem_responder #(
  parameter int          RAM_LOG2_BYTES = 14,
  parameter int          WAIT_STATES    = 1,
  parameter logic [31:0] TIMER_BASE     = 32'hAFFFFFE0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] daddress,
  input  logic        dwrite,
  input  logic [31:0] dwritedata,
  input  logic [3:0]  dbyteenable,
  input  logic        dread,
  output logic [31:0] dreaddata,
  output logic        dwaitrequest,
  input  logic [63:0] mtime_val,
  input  logic [63:0] mtimecmp_val,
  output logic        wr_mtime,
  output logic        wr_mtimecmp,
  output logic        wr_mtime_upper,
  output logic [31:0] wr_mtime_val,
  output logic        bus_error
);

  localparam int         WORDS  = 2 ** (RAM_LOG2_BYTES - 2);
  localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, BUSY, READY} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic [31:0] rdata_q;
  logic        wr_mtime_q, wr_mtimecmp_q, wr_upper_q, berr_q;
  logic [31:0] wr_val_q;

  logic [31:0] mem [WORDS];

  function automatic logic is_ram(input logic [31:0] a);
    return a[31:RAM_LOG2_BYTES] == '0;
  endfunction

  function automatic logic is_tmr(input logic [31:0] a);
    return a[31:4] == TIMER_BASE[31:4];
  endfunction

  logic wr_ram, wr_tmr, wr_unm, rd_fire;
  assign wr_ram  = dwrite & is_ram(daddress);
  assign wr_tmr  = dwrite & is_tmr(daddress);
  assign wr_unm  = dwrite & ~is_ram(daddress) & ~is_tmr(daddress);
  assign rd_fire = (state_q == BUSY) && (cnt_q == 4'd0);

  always_ff @(posedge clk) begin
    if (wr_ram) begin
      for (int b = 0; b < 4; b++)
        if (dbyteenable[b])
          mem[daddress[RAM_LOG2_BYTES-1:2]][8*b +: 8] <= dwritedata[8*b +: 8];
    end
  end

  // A write landing in the capture cycle is forwarded so the read sees it.
  logic [31:0] ram_fwd;
  always_comb begin
    ram_fwd = mem[addr_q[RAM_LOG2_BYTES-1:2]];
    if (wr_ram && daddress[RAM_LOG2_BYTES-1:2] == addr_q[RAM_LOG2_BYTES-1:2]) begin
      for (int b = 0; b < 4; b++)
        if (dbyteenable[b]) ram_fwd[8*b +: 8] = dwritedata[8*b +: 8];
    end
  end

  logic [31:0] rd_sel;
  always_comb begin
    rd_sel = '0;
    if (is_ram(addr_q)) begin
      rd_sel = ram_fwd;
    end else if (is_tmr(addr_q)) begin
      case (addr_q[3:2])
        2'd0:    rd_sel = mtime_val[31:0];
        2'd1:    rd_sel = mtime_val[63:32];
        2'd2:    rd_sel = mtimecmp_val[31:0];
        default: rd_sel = mtimecmp_val[63:32];
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      addr_q        <= '0;
      rdata_q       <= '0;
      wr_mtime_q    <= 1'b0;
      wr_mtimecmp_q <= 1'b0;
      wr_upper_q    <= 1'b0;
      wr_val_q      <= '0;
      berr_q        <= 1'b0;
    end else begin
      wr_mtime_q    <= wr_tmr & ~daddress[3];
      wr_mtimecmp_q <= wr_tmr & daddress[3];
      wr_upper_q    <= wr_tmr & daddress[2];
      wr_val_q      <= wr_tmr ? dwritedata : '0;
      berr_q        <= wr_unm | (rd_fire & ~is_ram(addr_q) & ~is_tmr(addr_q));
      case (state_q)
        IDLE: begin
          if (dread) begin
            addr_q  <= daddress;
            cnt_q   <= WS_CNT;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            rdata_q <= rd_sel;
            state_q <= READY;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dwaitrequest   = dread & (state_q != READY);
  assign dreaddata      = rdata_q;
  assign wr_mtime       = wr_mtime_q;
  assign wr_mtimecmp    = wr_mtimecmp_q;
  assign wr_mtime_upper = wr_upper_q;
  assign wr_mtime_val   = wr_val_q;
  assign bus_error      = berr_q;

endmodule

// File: tb/tb_rv32_dmem_responder.sv
// Directed bench: three responders (WAIT_STATES 1, 0, 15) share the bus inputs
// but each has its own dread so reads can be issued per instance.
module tb_rv32_dmem_responder;

  localparam logic [31:0] TB = 32'hAFFFFFE0;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] daddress;
  logic        dwrite;
  logic [31:0] dwritedata;
  logic [3:0]  dbyteenable;
  logic [63:0] mtime_val, mtimecmp_val;
  logic        dread [3];
  logic [31:0] rdata [3];
  logic        dwr   [3];
  logic        wrm   [3];
  logic        wrc   [3];
  logic        wru   [3];
  logic [31:0] wrv   [3];
  logic        berr  [3];

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WS = (g == 0) ? 1 : (g == 1) ? 0 : 15;
    rv32_dmem_responder #(.WAIT_STATES(WS)) dut (
      .clk(clk), .reset(reset), .daddress(daddress), .dwrite(dwrite),
      .dwritedata(dwritedata), .dbyteenable(dbyteenable), .dread(dread[g]),
      .dreaddata(rdata[g]), .dwaitrequest(dwr[g]), .mtime_val(mtime_val),
      .mtimecmp_val(mtimecmp_val), .wr_mtime(wrm[g]), .wr_mtimecmp(wrc[g]),
      .wr_mtime_upper(wru[g]), .wr_mtime_val(wrv[g]), .bus_error(berr[g])
    );
  end

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    vectors++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // Called at posedge+1. wr_at = cycle index (0 = request cycle) at which a
  // full-word write of wd to the same address is issued; -1 for none.
  task automatic rd(input int i, input logic [31:0] a, input int wr_at,
                    input logic [31:0] wd, output logic [31:0] d,
                    output int n, output logic be_o);
    bit done = 0;
    n = 0; d = '0; be_o = 1'b0;
    daddress = a; dread[i] = 1'b1;
    dwrite = (wr_at == 0); dwritedata = wd; dbyteenable = 4'hF;
    for (int c = 0; c < 64 && !done; c++) begin
      #1;
      if (!dwr[i]) begin
        d = rdata[i]; be_o = berr[i]; done = 1;
      end else begin
        n++;
        @(posedge clk); #1;
        dwrite = (n == wr_at);
      end
    end
    if (!done) n = 999;
    @(posedge clk); #1;
    dread[i] = 1'b0; dwrite = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    daddress = a; dwritedata = d; dbyteenable = be; dwrite = 1'b1;
    @(posedge clk); #1;
    dwrite = 1'b0;
    #1;
  endtask

  // Reset pulse two cycles into a read, then the held request must complete.
  task automatic rst_mid(input int i, input int ws, input logic [31:0] a, input logic [31:0] e);
    logic [31:0] d; int n; logic b;
    daddress = a; dread[i] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1; #1;
    chk($sformatf("rst_wait_ws%0d", ws), 64'(dwr[i]), 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    rd(i, a, -1, 32'h0, d, n, b);
    chk($sformatf("rst_lat_ws%0d", ws), 64'(n), 64'(ws + 2));
    chk($sformatf("rst_data_ws%0d", ws), 64'(d), 64'(e));
  endtask

  initial begin
    logic [31:0] d; int n; logic b;
    reset = 1'b1; daddress = '0; dwrite = 1'b0; dwritedata = '0;
    dbyteenable = '0; mtime_val = '0; mtimecmp_val = '0;
    dread[0] = 1'b1; dread[1] = 1'b0; dread[2] = 1'b0;
    #2;
    chk("rst_wait_follows_dread", 64'(dwr[0]), 64'd1);
    chk("rst_rdata", 64'(rdata[0]), 64'd0);
    chk("rst_strobes", {wrm[0], wrc[0], wru[0], berr[0]}, 64'd0);
    chk("rst_wrval", 64'(wrv[0]), 64'd0);
    dread[0] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    wr(32'h100, 32'hDEADBEEF, 4'hF);
    @(posedge clk); #1;
    rd(0, 32'h100, -1, 32'h0, d, n, b);
    chk("ws1_latency", 64'(n), 64'd3);
    chk("ws1_data", 64'(d), 64'hDEADBEEF);

    wr(32'h100, 32'h11223344, 4'h2);
    rd(0, 32'h100, -1, 32'h0, d, n, b);
    chk("byte_lane", 64'(d), 64'hDEAD33EF);

    wr(TB + 32'hC, 32'h5, 4'h0);
    chk("tmr_cmp_hi_strobe", {wrm[0], wrc[0], wru[0]}, 64'b011);
    chk("tmr_cmp_hi_val", 64'(wrv[0]), 64'd5);
    @(posedge clk); #1;
    chk("tmr_strobe_one_cycle", {wrm[0], wrc[0]}, 64'b00);
    wr(TB, 32'h77, 4'hF);
    chk("tmr_mtime_lo_strobe", {wrm[0], wrc[0], wru[0]}, 64'b100);
    chk("tmr_mtime_lo_val", 64'(wrv[0]), 64'h77);

    mtime_val = 64'h0000000A_00000000;
    mtimecmp_val = 64'h00000003_00000007;
    @(posedge clk); #1;
    rd(0, TB + 32'h4, -1, 32'h0, d, n, b);
    chk("tmr_rd_mtime_hi", 64'(d), 64'hA);
    rd(0, TB + 32'h8, -1, 32'h0, d, n, b);
    chk("tmr_rd_cmp_lo", 64'(d), 64'h7);
    rd(0, TB + 32'hC, -1, 32'h0, d, n, b);
    chk("tmr_rd_cmp_hi", 64'(d), 64'h3);

    rd(0, 32'h80000000, -1, 32'h0, d, n, b);
    chk("unm_rd_data", 64'(d), 64'd0);
    chk("unm_rd_berr", 64'(b), 64'd1);
    chk("unm_rd_berr_clear", 64'(berr[0]), 64'd0);
    wr(32'h80000100, 32'hFFFFFFFF, 4'hF);
    chk("unm_wr_berr", {berr[0], wrm[0], wrc[0]}, 64'b100);
    @(posedge clk); #1;
    chk("unm_wr_berr_clear", 64'(berr[0]), 64'd0);
    rd(0, 32'h100, -1, 32'h0, d, n, b);
    chk("unm_wr_no_ram", 64'(d), 64'hDEAD33EF);

    rd(0, 32'h200, 0, 32'h12345678, d, n, b);
    chk("same_cycle_lat", 64'(n), 64'd3);
    chk("same_cycle_data", 64'(d), 64'h12345678);

    wr(32'h304, 32'h11111111, 4'hF);
    rd(0, 32'h304, 2, 32'h0BADC0DE, d, n, b);
    chk("capture_cycle_wr", 64'(d), 64'h0BADC0DE);
    wr(32'h300, 32'h22222222, 4'hF);
    rd(2, 32'h300, 5, 32'hCAFEF00D, d, n, b);
    chk("busy_wr_data", 64'(d), 64'hCAFEF00D);
    chk("ws15_latency", 64'(n), 64'd17);
    rd(1, 32'h100, -1, 32'h0, d, n, b);
    chk("ws0_latency", 64'(n), 64'd2);
    chk("ws0_data", 64'(d), 64'hDEAD33EF);

    rst_mid(0, 1, 32'h100, 32'hDEAD33EF);
    rst_mid(1, 0, 32'h200, 32'h12345678);
    rst_mid(2, 15, 32'h304, 32'h0BADC0DE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
